// File: rtl/stream_pkg.sv
// Shared definitions for the narrow/wide stream width converters.
//
// Contents:
//   BEAT_ORDER_*  encoding of the LSB_FIRST parameter (which slice of a wide
//                 word travels first); shared with the deserializer so both
//                 ends of a link agree on beat order.
//   cnt_w()       width of a beat counter that indexes 0..ratio-1, never
//                 narrower than one bit.
package stream_pkg;

  localparam bit BEAT_ORDER_MSB_FIRST = 1'b0;
  localparam bit BEAT_ORDER_LSB_FIRST = 1'b1;

  function automatic int cnt_w(int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_serializer.sv
// Ready/valid width converter: accepts one RATIO*WIDTH-bit word and emits it
// as RATIO beats of WIDTH bits, flagging the final beat with last_o.
// An active word (being shifted out) plus one staging word give a full
// one-beat-per-cycle stream while every output, ready_i included, comes
// straight from a flop.
//
// Ports:
//   clk      in   rising-edge clock
//   arst     in   synchronous, active-high reset
//   valid_i  in   input word valid
//   dat_i    in   input word, RATIO*WIDTH bits
//   ready_i  out  block can accept a word (registered)
//   valid_o  out  output beat valid (registered)
//   dat_o    out  output beat, WIDTH bits (registered)
//   last_o   out  current beat is the last of its word (registered)
//   ready_o  in   downstream accepts the beat
module stream_serializer
  import stream_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = BEAT_ORDER_LSB_FIRST
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     valid_i,
  input  logic [WIDTH*RATIO-1:0]   dat_i,
  output logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         dat_o,
  output logic                     last_o,
  input  logic                     ready_o
);

  localparam int              WW       = WIDTH * RATIO;
  localparam int              CW       = cnt_w(RATIO);
  localparam logic [CW-1:0]   CNT_LAST = CW'(RATIO - 1);

  if (RATIO < 1 || WIDTH < 1) begin : g_param_check
    $error("stream_serializer: RATIO and WIDTH must both be at least 1");
  end

  // Beat k of a word, honouring the configured beat order.
  function automatic logic [WIDTH-1:0] slice(input logic [WW-1:0] w,
                                             input logic [CW-1:0] k);
    int idx;
    idx = (LSB_FIRST == BEAT_ORDER_LSB_FIRST) ? int'(k) : (RATIO - 1 - int'(k));
    return w[idx*WIDTH +: WIDTH];
  endfunction

  logic [WW-1:0]    act_word, act_word_nxt;
  logic [WW-1:0]    stg_word, stg_word_nxt;
  logic             stg_valid, stg_valid_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             valid_nxt, last_nxt, ready_nxt;
  logic [WIDTH-1:0] dat_nxt;

  logic in_acc, out_acc, last_acc;

  assign in_acc   = valid_i && ready_i;
  assign out_acc  = valid_o && ready_o;
  assign last_acc = out_acc && (cnt == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    act_word_nxt  = act_word;
    stg_word_nxt  = stg_word;
    stg_valid_nxt = stg_valid;
    cnt_nxt       = cnt;
    valid_nxt     = valid_o;

    if (out_acc) begin
      if (!last_acc) begin
        cnt_nxt = cnt + CW'(1);
      end else if (stg_valid) begin
        act_word_nxt  = stg_word;
        cnt_nxt       = '0;
        stg_valid_nxt = 1'b0;
      end else begin
        valid_nxt = 1'b0;
      end
    end

    // ready_i is low whenever staging is full, so an accepted word always
    // finds either an active slot that is free (or freeing now) or an empty
    // staging slot.
    if (in_acc) begin
      if (!valid_o || last_acc) begin
        act_word_nxt = dat_i;
        cnt_nxt      = '0;
        valid_nxt    = 1'b1;
      end else begin
        stg_word_nxt  = dat_i;
        stg_valid_nxt = 1'b1;
      end
    end

    // Outputs are precomputed from next-state so they can be registered.
    dat_nxt   = slice(act_word_nxt, cnt_nxt);
    last_nxt  = valid_nxt && (cnt_nxt == CNT_LAST);
    ready_nxt = !stg_valid_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (arst) begin
      // NOTE: the word registers are cleared as well, so a reset mid-word
      // leaves nothing behind that could later surface as a partial word.
      act_word  <= '0;
      stg_word  <= '0;
      stg_valid <= 1'b0;
      cnt       <= '0;
      valid_o   <= 1'b0;
      dat_o     <= '0;
      last_o    <= 1'b0;
      ready_i   <= 1'b0;
    end else begin
      act_word  <= act_word_nxt;
      stg_word  <= stg_word_nxt;
      stg_valid <= stg_valid_nxt;
      cnt       <= cnt_nxt;
      valid_o   <= valid_nxt;
      dat_o     <= dat_nxt;
      last_o    <= last_nxt;
      ready_i   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer.
// Three instances: WIDTH=8/RATIO=4 LSB-first (main), WIDTH=8/RATIO=4
// MSB-first, and WIDTH=8/RATIO=1. The main instance is driven from a table
// of {inputs, expected outputs}; the other cases are short directed runs.
module tb_stream_serializer;

  logic clk;
  logic arst;

  // main instance: LSB first, RATIO=4
  logic        a_valid_i, a_ready_i, a_valid_o, a_last_o, a_ready_o;
  logic [31:0] a_dat_i;
  logic [7:0]  a_dat_o;

  // MSB-first instance
  logic        m_valid_i, m_ready_i, m_valid_o, m_last_o, m_ready_o;
  logic [31:0] m_dat_i;
  logic [7:0]  m_dat_o;

  // RATIO=1 instance
  logic        r_valid_i, r_ready_i, r_valid_o, r_last_o, r_ready_o;
  logic [7:0]  r_dat_i;
  logic [7:0]  r_dat_o;

  int n_cmp = 0;
  int n_bad = 0;

  stream_serializer #(.WIDTH(8), .RATIO(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .arst(arst), .valid_i(a_valid_i), .dat_i(a_dat_i),
    .ready_i(a_ready_i), .valid_o(a_valid_o), .dat_o(a_dat_o),
    .last_o(a_last_o), .ready_o(a_ready_o)
  );

  stream_serializer #(.WIDTH(8), .RATIO(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .arst(arst), .valid_i(m_valid_i), .dat_i(m_dat_i),
    .ready_i(m_ready_i), .valid_o(m_valid_o), .dat_o(m_dat_o),
    .last_o(m_last_o), .ready_o(m_ready_o)
  );

  stream_serializer #(.WIDTH(8), .RATIO(1), .LSB_FIRST(1'b1)) u_r1 (
    .clk(clk), .arst(arst), .valid_i(r_valid_i), .dat_i(r_dat_i),
    .ready_i(r_ready_i), .valid_o(r_valid_o), .dat_o(r_dat_o),
    .last_o(r_last_o), .ready_o(r_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vi;
    logic [31:0] di;
    logic        ro;
    logic        er;  // expected ready_i
    logic        ev;  // expected valid_o
    logic [7:0]  ed;  // expected dat_o (checked only when ev)
    logic        el;  // expected last_o
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic vi, logic [31:0] di, logic ro,
                              logic er, logic ev, logic [7:0] ed, logic el);
    vec_t v;
    v.vi = vi; v.di = di; v.ro = ro;
    v.er = er; v.ev = ev; v.ed = ed; v.el = el;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic er, input logic ev,
                       input logic [7:0] ed, input logic el);
    check({tag, " ready_i"}, {31'd0, a_ready_i}, {31'd0, er});
    check({tag, " valid_o"}, {31'd0, a_valid_o}, {31'd0, ev});
    if (ev) check({tag, " dat_o"}, {24'd0, a_dat_o}, {24'd0, ed});
    check({tag, " last_o"}, {31'd0, a_last_o}, {31'd0, el});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msb_exp [4];

    arst = 1'b1;
    a_valid_i = 1'b0; a_dat_i = '0; a_ready_o = 1'b1;
    m_valid_i = 1'b0; m_dat_i = '0; m_ready_o = 1'b1;
    r_valid_i = 1'b0; r_dat_i = '0; r_ready_o = 1'b1;

    // ---------------- vector table (main instance) ----------------
    // single word
    add(1, 32'hDDCCBBAA, 1,  1, 1, 8'hAA, 0);
    add(0, 32'h0,        1,  1, 1, 8'hBB, 0);
    add(0, 32'h0,        1,  1, 1, 8'hCC, 0);
    add(0, 32'h0,        1,  1, 1, 8'hDD, 1);
    add(0, 32'h0,        1,  1, 0, 8'h00, 0);
    // back-to-back: second word goes to staging, ready_i drops then recovers
    add(1, 32'h03020100, 1,  1, 1, 8'h00, 0);
    add(1, 32'h07060504, 1,  0, 1, 8'h01, 0);
    add(0, 32'h0,        1,  0, 1, 8'h02, 0);
    add(0, 32'h0,        1,  0, 1, 8'h03, 1);
    add(0, 32'h0,        1,  1, 1, 8'h04, 0);
    add(0, 32'h0,        1,  1, 1, 8'h05, 0);
    add(0, 32'h0,        1,  1, 1, 8'h06, 0);
    add(0, 32'h0,        1,  1, 1, 8'h07, 1);
    add(0, 32'h0,        1,  1, 0, 8'h00, 0);
    // backpressure on beat BB for 5 cycles
    add(1, 32'hDDCCBBAA, 1,  1, 1, 8'hAA, 0);
    add(0, 32'h0,        1,  1, 1, 8'hBB, 0);
    for (int i = 0; i < 5; i++) add(0, 32'h0, 0,  1, 1, 8'hBB, 0);
    add(0, 32'h0,        1,  1, 1, 8'hCC, 0);
    add(0, 32'h0,        1,  1, 1, 8'hDD, 1);
    add(0, 32'h0,        1,  1, 0, 8'h00, 0);
    // staging fills during a stall; a third word is refused while full
    add(1, 32'h03020100, 0,  1, 1, 8'h00, 0);
    add(1, 32'h07060504, 0,  0, 1, 8'h00, 0);
    add(1, 32'h0B0A0908, 0,  0, 1, 8'h00, 0);
    add(0, 32'h0,        1,  0, 1, 8'h01, 0);
    add(0, 32'h0,        1,  0, 1, 8'h02, 0);
    add(0, 32'h0,        1,  0, 1, 8'h03, 1);
    add(0, 32'h0,        1,  1, 1, 8'h04, 0);
    add(0, 32'h0,        1,  1, 1, 8'h05, 0);
    add(0, 32'h0,        1,  1, 1, 8'h06, 0);
    add(0, 32'h0,        1,  1, 1, 8'h07, 1);
    add(0, 32'h0,        1,  1, 0, 8'h00, 0);
    // new word accepted in the same cycle as the last beat: no bubble
    add(1, 32'h03020100, 1,  1, 1, 8'h00, 0);
    add(0, 32'h0,        1,  1, 1, 8'h01, 0);
    add(0, 32'h0,        1,  1, 1, 8'h02, 0);
    add(0, 32'h0,        1,  1, 1, 8'h03, 1);
    add(1, 32'h07060504, 1,  1, 1, 8'h04, 0);
    add(0, 32'h0,        1,  1, 1, 8'h05, 0);
    add(0, 32'h0,        1,  1, 1, 8'h06, 0);
    add(0, 32'h0,        1,  1, 1, 8'h07, 1);
    add(0, 32'h0,        1,  1, 0, 8'h00, 0);

    // ---------------- reset values ----------------
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a($sformatf("reset%0d", i), 1'b0, 1'b0, 8'h00, 1'b0);
      check($sformatf("reset%0d dat_o", i), {24'd0, a_dat_o}, 32'd0);
    end
    arst = 1'b0;
    tick();
    chk_a("release", 1'b1, 1'b0, 8'h00, 1'b0);
    check("release r1 ready_i", {31'd0, r_ready_i}, 32'd1);

    // ---------------- table-driven run ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      a_valid_i = vecs[i].vi;
      a_dat_i   = vecs[i].di;
      a_ready_o = vecs[i].ro;
      tick();
      chk_a($sformatf("vec%0d", i), vecs[i].er, vecs[i].ev, vecs[i].ed, vecs[i].el);
    end
    a_valid_i = 1'b0;
    a_ready_o = 1'b1;

    // ---------------- reset mid-word ----------------
    a_valid_i = 1'b1; a_dat_i = 32'hDDCCBBAA;
    tick();
    chk_a("midrst load", 1'b1, 1'b1, 8'hAA, 1'b0);
    a_valid_i = 1'b0;
    tick();
    chk_a("midrst beat1", 1'b1, 1'b1, 8'hBB, 1'b0);
    arst = 1'b1;
    tick();
    chk_a("midrst in reset", 1'b0, 1'b0, 8'h00, 1'b0);
    arst = 1'b0;
    tick();
    chk_a("midrst release", 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    chk_a("midrst idle", 1'b1, 1'b0, 8'h00, 1'b0);
    a_valid_i = 1'b1; a_dat_i = 32'h03020100;
    tick();
    chk_a("midrst new word", 1'b1, 1'b1, 8'h00, 1'b0);
    a_valid_i = 1'b0;
    tick();
    chk_a("midrst new beat1", 1'b1, 1'b1, 8'h01, 1'b0);

    // ---------------- MSB first ----------------
    msb_exp[0] = 8'hDD; msb_exp[1] = 8'hCC; msb_exp[2] = 8'hBB; msb_exp[3] = 8'hAA;
    m_valid_i = 1'b1; m_dat_i = 32'hDDCCBBAA;
    for (int k = 0; k < 4; k++) begin
      tick();
      m_valid_i = 1'b0;
      check($sformatf("msb beat%0d valid_o", k), {31'd0, m_valid_o}, 32'd1);
      check($sformatf("msb beat%0d dat_o", k), {24'd0, m_dat_o}, {24'd0, msb_exp[k]});
      check($sformatf("msb beat%0d last_o", k), {31'd0, m_last_o}, {31'd0, (k == 3)});
    end
    tick();
    check("msb end valid_o", {31'd0, m_valid_o}, 32'd0);

    // ---------------- RATIO=1 sustained ----------------
    for (int k = 0; k < 4; k++) begin
      r_valid_i = 1'b1;
      r_dat_i   = 8'(8'h11 * (k + 1));
      tick();
      check($sformatf("r1 beat%0d valid_o", k), {31'd0, r_valid_o}, 32'd1);
      check($sformatf("r1 beat%0d dat_o", k), {24'd0, r_dat_o}, {24'd0, 8'(8'h11 * (k + 1))});
      check($sformatf("r1 beat%0d last_o", k), {31'd0, r_last_o}, 32'd1);
      check($sformatf("r1 beat%0d ready_i", k), {31'd0, r_ready_i}, 32'd1);
    end
    r_valid_i = 1'b0;
    tick();
    check("r1 drained valid_o", {31'd0, r_valid_o}, 32'd0);

    // RATIO=1 one-word skid under backpressure
    r_valid_i = 1'b1; r_dat_i = 8'hAA; r_ready_o = 1'b1;
    tick();
    check("r1 skid first dat_o", {24'd0, r_dat_o}, 32'h0000_00AA);
    r_dat_i = 8'hBB; r_ready_o = 1'b0;
    tick();
    check("r1 skid stall dat_o", {24'd0, r_dat_o}, 32'h0000_00AA);
    check("r1 skid stall ready_i", {31'd0, r_ready_i}, 32'd0);
    r_valid_i = 1'b0; r_ready_o = 1'b1;
    tick();
    check("r1 skid second dat_o", {24'd0, r_dat_o}, 32'h0000_00BB);
    check("r1 skid second valid_o", {31'd0, r_valid_o}, 32'd1);
    check("r1 skid second ready_i", {31'd0, r_ready_i}, 32'd1);
    tick();
    check("r1 skid end valid_o", {31'd0, r_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
